// File: rtl/mii_pkg.sv
// ---------------------------------------------------------------------------
// mii_pkg
// Shared definitions for the 64-bit MII receive path:
//   - MII control characters (idle / start / terminate), preamble and SFD
//   - receive FSM state enum
//   - Ethernet framing sizes and error-vector bit positions
//   - CRC-32 constants and a byte-serial reflected CRC-32 step
// No ports (package).
// ---------------------------------------------------------------------------
package mii_pkg;

  // Control characters carried on a lane whose ctrl bit is 1.
  localparam logic [7:0] MII_IDLE  = 8'h07;
  localparam logic [7:0] MII_START = 8'hFB;
  localparam logic [7:0] MII_TERM  = 8'hFD;

  // Data bytes that complete the start word.
  localparam logic [7:0] MII_PREAMBLE = 8'h55;
  localparam logic [7:0] MII_SFD      = 8'hD5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DROP  = 2'd3
  } rx_state_e;

  localparam int ETH_HDR_BYTES = 14;
  localparam int ETH_FCS_BYTES = 4;
  localparam int ETH_MIN_FRAME = ETH_HDR_BYTES + ETH_FCS_BYTES;

  // Bit positions inside the 4-bit error vector.
  localparam int ERR_FCS      = 0;
  localparam int ERR_RUNT     = 1;
  localparam int ERR_OVERSIZE = 2;
  localparam int ERR_PROTO    = 3;

  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  // Register value left behind after running the CRC over data plus a good FCS.
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  // One byte through the reflected CRC-32, LSB first as on the wire.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_mii_update.sv
// ---------------------------------------------------------------------------
// crc32_mii_update
// Combinational CRC-32 update across one 64-bit MII word. Lanes are folded in
// lane order (lane 0 first on the wire); a lane contributes only when its
// enable bit is set. Built only when MII_RX_CRC_CHECK_EN is defined.
// Ports:
//   data     in  64  lane k is byte [8k+7:8k]
//   lane_en  in  8   bit k=1 folds lane k into the CRC
//   crc_in   in  32  current CRC register
//   crc_out  out 32  CRC after the enabled lanes
// ---------------------------------------------------------------------------
`ifdef MII_RX_CRC_CHECK_EN
module crc32_mii_update
  import mii_pkg::*;
(
  input  logic [63:0] data,
  input  logic [7:0]  lane_en,
  input  logic [31:0] crc_in,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int k = 0; k < 8; k++) begin
      if (lane_en[k]) begin
        crc_out = crc32_byte(crc_out, data[8*k +: 8]);
      end
    end
  end

endmodule
`endif

// File: rtl/mii_mac_rx.sv
// ---------------------------------------------------------------------------
// mii_mac_rx
// Receive-side MAC frame checker on the 64-bit, 8-lane MII word stream.
// Strips start/preamble/SFD, captures destination, source, EtherType and
// payload, checks length (and FCS when MII_RX_CRC_CHECK_EN is defined), then
// reports each frame with a one-cycle done pulse plus an error vector.
//
// Optional feature: define MII_RX_CRC_CHECK_EN to build the CRC-32 checker.
// Without it the FCS bytes are stripped unchecked and o_err[0] stays 0.
//
// Ports:
//   clk               in  1    rising-edge clock
//   i_rst_n           in  1    asynchronous active-low reset
//   i_mii_data        in  64   lane k = byte [8k+7:8k], lane 0 first
//   i_mii_ctrl        in  8    bit k=1: lane k is a control character
//   o_dest_address    out 48   first received byte in [47:40]
//   o_src_address     out 48   first received byte in [47:40]
//   o_eth_type        out 16   first received byte in [15:8]
//   o_payload         out 8*PAYLOAD_MAX_SIZE  byte i in [8i+7:8i]
//   o_payload_length  out 16   frame bytes minus 18
//   o_frame_done      out 1    one-cycle report pulse
//   o_frame_ok        out 1    no error bit set (valid with o_frame_done)
//   o_err             out 4    {protocol, oversize, runt, fcs}
//   o_busy            out 1    FSM not in IDLE
//   dbg_state         out 2    current FSM state
//
// Flow control: the input stream has no valid/ready pair; a word is consumed
// on every rising edge and the block never stalls its source.
// ---------------------------------------------------------------------------
module mii_mac_rx
  import mii_pkg::*;
#(
  parameter int PAYLOAD_MAX_SIZE = 64
) (
  input  logic                            clk,
  input  logic                            i_rst_n,
  input  logic [63:0]                     i_mii_data,
  input  logic [7:0]                      i_mii_ctrl,
  output logic [47:0]                     o_dest_address,
  output logic [47:0]                     o_src_address,
  output logic [15:0]                     o_eth_type,
  output logic [8*PAYLOAD_MAX_SIZE-1:0]   o_payload,
  output logic [15:0]                     o_payload_length,
  output logic                            o_frame_done,
  output logic                            o_frame_ok,
  output logic [3:0]                      o_err,
  output logic                            o_busy,
  output rx_state_e                       dbg_state
);

  localparam logic [63:0] START_WORD = {MII_SFD, {6{MII_PREAMBLE}}, MII_START};

  rx_state_e state_q, state_d;

  // -------------------------------------------------------------------------
  // Word decode
  // -------------------------------------------------------------------------
  logic [3:0] first_ctrl;   // index of the lowest control lane, 8 if none
  logic [7:0] first_byte;   // character in that lane
  logic       has_term;     // any lane carries a terminate
  logic       is_start;
  logic       bad_start;
  logic       all_idle;
  logic       first_is_term;
  logic [3:0] nbytes;       // data lanes below the first control lane

  always_comb begin
    first_ctrl = 4'd8;
    first_byte = 8'h00;
    has_term   = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (i_mii_ctrl[k]) begin
        first_ctrl = 4'(k);
        first_byte = i_mii_data[8*k +: 8];
      end
    end
    for (int k = 0; k < 8; k++) begin
      if (i_mii_ctrl[k] && (i_mii_data[8*k +: 8] == MII_TERM)) begin
        has_term = 1'b1;
      end
    end
    is_start      = (i_mii_ctrl == 8'h01) && (i_mii_data == START_WORD);
    // A start character in lane 0 with anything wrong after it.
    bad_start     = i_mii_ctrl[0] && (i_mii_data[7:0] == MII_START) && !is_start;
    all_idle      = (i_mii_ctrl == 8'hFF) && (i_mii_data == {8{MII_IDLE}});
    first_is_term = (first_ctrl != 4'd8) && (first_byte == MII_TERM);
    nbytes        = first_ctrl;
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (is_start) begin
          state_d = ST_DATA;
        end else if (bad_start) begin
          state_d = ST_DROP;
        end
      end
      ST_DATA: begin
        if (first_ctrl == 4'd8) begin
          state_d = ST_DATA;
        end else if (first_is_term) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_DROP;
        end
      end
      // Whatever arrives during CHECK, including a start word, is ignored.
      ST_CHECK: state_d = ST_IDLE;
      ST_DROP: begin
        if (has_term || all_idle) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs / datapath controls
  // -------------------------------------------------------------------------
  logic clear_capture;
  logic take_bytes;
  logic report_check;
  logic report_drop;

  always_comb begin
    clear_capture = 1'b0;
    take_bytes    = 1'b0;
    report_check  = 1'b0;
    report_drop   = 1'b0;
    case (state_q)
      ST_IDLE:  clear_capture = is_start;
      // Bytes are taken only from words that keep the frame alive.
      ST_DATA:  take_bytes = (first_ctrl == 4'd8) || first_is_term;
      ST_CHECK: report_check = 1'b1;
      ST_DROP:  report_drop = has_term || all_idle;
      default: ;
    endcase
  end

  assign o_busy    = (state_q != ST_IDLE);
  assign dbg_state = state_q;

  // -------------------------------------------------------------------------
  // Byte lanes: enable and absolute frame index per lane
  // -------------------------------------------------------------------------
  logic [15:0] cnt_q;
  logic [16:0] cnt_sum;
  logic [15:0] cnt_next;
  logic [7:0]  lane_en;
  logic [16:0] lane_idx [8];

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      lane_en[k]  = take_bytes && (4'(k) < nbytes);
      // 17 bits so a saturated counter cannot wrap back into the header range.
      lane_idx[k] = {1'b0, cnt_q} + 17'(k);
    end
    cnt_sum  = {1'b0, cnt_q} + {13'd0, nbytes};
    cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  // -------------------------------------------------------------------------
  // Capture registers
  // -------------------------------------------------------------------------
  logic [47:0]                   dest_q;
  logic [47:0]                   src_q;
  logic [15:0]                   type_q;
  logic [8*PAYLOAD_MAX_SIZE-1:0] buf_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      dest_q <= '0;
      src_q  <= '0;
      type_q <= '0;
      buf_q  <= '0;
    end else if (clear_capture) begin
      cnt_q  <= '0;
      dest_q <= '0;
      src_q  <= '0;
      type_q <= '0;
      buf_q  <= '0;
    end else if (take_bytes) begin
      cnt_q <= cnt_next;
      for (int k = 0; k < 8; k++) begin
        if (lane_en[k]) begin
          for (int i = 0; i < 6; i++) begin
            if (lane_idx[k] == 17'(i)) dest_q[(5-i)*8 +: 8] <= i_mii_data[8*k +: 8];
            if (lane_idx[k] == 17'(6 + i)) src_q[(5-i)*8 +: 8] <= i_mii_data[8*k +: 8];
          end
          for (int i = 0; i < 2; i++) begin
            if (lane_idx[k] == 17'(12 + i)) type_q[(1-i)*8 +: 8] <= i_mii_data[8*k +: 8];
          end
          // FCS bytes land here too; they are masked off when reporting.
          for (int i = 0; i < PAYLOAD_MAX_SIZE; i++) begin
            if (lane_idx[k] == 17'(ETH_HDR_BYTES + i)) buf_q[8*i +: 8] <= i_mii_data[8*k +: 8];
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // FCS check
  // -------------------------------------------------------------------------
  logic crc_err;

`ifdef MII_RX_CRC_CHECK_EN
  logic [31:0] crc_q;
  logic [31:0] crc_next;

  crc32_mii_update u_crc (
    .data    (i_mii_data),
    .lane_en (lane_en),
    .crc_in  (crc_q),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      crc_q <= CRC_INIT;
    end else if (clear_capture) begin
      crc_q <= CRC_INIT;
    end else if (take_bytes) begin
      crc_q <= crc_next;
    end
  end

  // Running over the FCS as well leaves a fixed residue on a good frame.
  assign crc_err = (crc_q != CRC_RESIDUE);
`else
  assign crc_err = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Length checks and payload trim
  // -------------------------------------------------------------------------
  logic [15:0]                   keep;
  logic                          runt;
  logic                          oversize;
  logic [3:0]                    err_chk;
  logic [8*PAYLOAD_MAX_SIZE-1:0] payload_trim;

  always_comb begin
    runt     = (cnt_q < 16'(ETH_MIN_FRAME));
    keep     = runt ? 16'd0 : (cnt_q - 16'(ETH_MIN_FRAME));
    oversize = (keep > 16'(PAYLOAD_MAX_SIZE));
    err_chk               = '0;
    err_chk[ERR_FCS]      = crc_err;
    err_chk[ERR_RUNT]     = runt;
    err_chk[ERR_OVERSIZE] = oversize;
    // Buffer slots at or past the payload length hold FCS bytes: zero them.
    for (int i = 0; i < PAYLOAD_MAX_SIZE; i++) begin
      payload_trim[8*i +: 8] = (16'(i) < keep) ? buf_q[8*i +: 8] : 8'h00;
    end
  end

  // -------------------------------------------------------------------------
  // Report registers: loaded at the end of CHECK, or when DROP resolves.
  // A dropped frame keeps the previous fields and reports only the protocol
  // error.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dest_address   <= '0;
      o_src_address    <= '0;
      o_eth_type       <= '0;
      o_payload        <= '0;
      o_payload_length <= '0;
      o_frame_done     <= 1'b0;
      o_frame_ok       <= 1'b0;
      o_err            <= '0;
    end else if (report_check) begin
      o_dest_address   <= dest_q;
      o_src_address    <= src_q;
      o_eth_type       <= type_q;
      o_payload        <= payload_trim;
      o_payload_length <= keep;
      o_frame_done     <= 1'b1;
      o_frame_ok       <= (err_chk == 4'd0);
      o_err            <= err_chk;
    end else if (report_drop) begin
      o_frame_done     <= 1'b1;
      o_frame_ok       <= 1'b0;
      o_err            <= 4'b1000;
    end else begin
      o_frame_done     <= 1'b0;
    end
  end

endmodule
